// File: rtl/mdr_mem_interface_if.sv
// MDR / memory sequencer bundle: control-unit side and RAM side.
// The slave modport is the sequencer; the master modport drives it.
interface mdr_mem_interface_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic [DATA_W-1:0] BusMuxOut;
  logic              MDRin;
  logic              rd_start;
  logic              wr_start;
  logic [ADDR_W-1:0] mar_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] BusMuxIn_MDR;
  logic              busy;
  logic              done;

  modport slave (
    input  BusMuxOut, MDRin, rd_start,
    input  wr_start, mar_addr, mem_rdata,
    output mem_addr, mem_wdata, mem_re,
    output mem_we, BusMuxIn_MDR, busy, done
  );

  modport master (
    output BusMuxOut, MDRin, rd_start,
    output wr_start, mar_addr, mem_rdata,
    input  mem_addr, mem_wdata, mem_re,
    input  mem_we, BusMuxIn_MDR, busy, done
  );
endinterface

// File: rtl/mdr_mem_interface.sv
// Memory Data Register with single-word read/write sequencer
// for a fixed-latency synchronous RAM.
module mdr_mem_interface #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 1
) (
  input  logic clock,
  input  logic clear,
  mdr_mem_interface_if.slave bus
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] mdr, mdr_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              re_q, re_n;
  logic              we_q, we_n;
  logic [CW-1:0]     cnt, cnt_n;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      mdr     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      mdr     <= mdr_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      re_q    <= re_n;
      we_q    <= we_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    mdr_n   = mdr;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    re_n    = 1'b0;
    we_n    = 1'b0;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.MDRin) mdr_n = bus.BusMuxOut;
        // write data is the pre-edge MDR, even if MDRin loads now
        if (bus.rd_start) begin
          state_n = RD_REQ;
          addr_n  = bus.mar_addr;
          re_n    = 1'b1;
        end else if (bus.wr_start) begin
          state_n = WR_REQ;
          addr_n  = bus.mar_addr;
          wdata_n = mdr;
          we_n    = 1'b1;
        end
      end
      RD_REQ: begin
        state_n = RD_WAIT;
        cnt_n   = LAT_M1;
      end
      RD_WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          mdr_n   = bus.mem_rdata;
          state_n = DONE;
        end
      end
      WR_REQ:  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_re       = re_q;
  assign bus.mem_we       = we_q;
  assign bus.BusMuxIn_MDR = mdr;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);
endmodule
